mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Target-side endpoint for the processor's 16-bit memory bus. It serves the CPU's address, read, write and write-data signals and returns registered read data.
- Backs the bus with an on-chip RAM plus a small memory-mapped I/O page: LED register, switch input, free-running cycle counter, and a 4-deep byte TX FIFO with a valid/ready drain port.
- Sits between the cpu and board I/O in the top level.

Parameters:
- RAM_WORDS, 4096: RAM depth in 16-bit words. Must be a power of two, at most 16384.
- MMIO_BASE, 16'hF000: byte address of the I/O page. Must be aligned to 16 bytes.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_mem_addr  input  16  byte address from CPU; bit 0 ignored
- i_mem_rd  input  1  read strobe
- i_mem_wr  input  1  write strobe
- i_mem_wrdata  input  16  write data
- o_mem_rddata  output  16  registered read data
- o_leds  output  16  LED register contents
- i_switches  input  16  asynchronous switch inputs
- o_tx_data  output  8  TX FIFO head byte
- o_tx_valid  output  1  TX FIFO non-empty
- i_tx_ready  input  1  consumer accepts head byte this cycle

Behaviour:
- Clock and reset: clk, rising edge; reset is asynchronous, active-high.
- Reset values:
  - o_mem_rddata = 0, o_leds = 0, cycle counter = 0, switch synchronizer = 0.
  - FIFO empty (o_tx_valid = 0, o_tx_data = 0), overflow flag = 0.
  - RAM contents are not reset.
- Address decode (byte addresses, word index = addr[15:1]):
  - RAM: addr < 2*RAM_WORDS; index addr[log2(RAM_WORDS):1].
  - MMIO: MMIO_BASE <= addr < MMIO_BASE+16.
  - Unmapped: everything else. Reads return 0; writes are ignored.
- MMIO map (offsets from MMIO_BASE):
  - +0 LED: R/W; write sets o_leds.
  - +2 SW: RO; i_switches through a 2-flop synchronizer.
  - +4 CYC: RO; 16-bit free-running counter, +1 every cycle, wraps FFFF->0000.
  - +6 TXD: WO; write pushes i_mem_wrdata[7:0]. Reads return 0.
  - +8 STAT: reads {10'b0, count[2:0], ovf, full, empty}. Writing with bit2=1 clears ovf.
  - +A..+E: read 0, writes ignored.
- Read timing:
  - When i_mem_rd=1 at edge N, o_mem_rddata shows the addressed data after edge N (one-cycle latency).
  - When i_mem_rd=0, o_mem_rddata holds its value.
  - CYC returns the counter value before edge N's increment.
- Write timing: commits at the rising edge where i_mem_wr=1.
- Same-cycle read and write:
  - Same address: read returns the old value (read-before-write). Applies to RAM, LED and STAT.
  - Different addresses: both proceed independently.
- TX FIFO, 4 entries, 8 bits wide:
  - o_tx_valid = !empty; o_tx_data = head entry; 0 when empty.
  - Pop happens on an edge where o_tx_valid & i_tx_ready.
  - Push is accepted if count<4, or if count==4 and a pop occurs the same edge.
  - A rejected push leaves the FIFO unchanged and sets ovf (sticky).
  - Simultaneous push and pop at count 1..3: count unchanged.
  - Push when empty: the data appears on o_tx_data the next cycle.
  - Pointers wrap modulo 4; count range is 0..4.
  - A push to TXD and a STAT clear can occur in different cycles only; the bus carries one address per cycle.
- Reset mid-operation: all state above returns to reset values immediately; the FIFO is discarded.

Test Plan:
1. Write RAM 0x0010=0xBEEF, then read 0x0010 → rddata=0xBEEF one cycle after the read. Read 0x0011 → also 0xBEEF.
2. Write 0x0020=0x1111. In the next cycle, read+write 0x0020 with 0x2222 → rddata=0x1111; a following read returns 0x2222.
3. Write LED (0xF000)=0x00A5 → o_leds=0x00A5 after the edge. Drive i_switches=0x1234, wait 2 cycles, read 0xF002 → 0x1234. Read unmapped 0x8000 → 0x0000.
4. Release reset, then read CYC at two edges 10 cycles apart → values differ by exactly 10. Force the counter to 0xFFFF → the next read shows 0x0000 (wrap).
5. With i_tx_ready=0, push 0x41,0x42,0x43,0x44,0x45 → STAT=0x0026 (count=4, full, ovf); o_tx_data=0x41. Raise ready for 4 cycles → bytes 0x41..0x44 in order, then o_tx_valid=0. Write STAT bit2 → STAT=0x0001.
6. FIFO full with i_tx_ready=1 and a push of 0x55 in the same cycle → push accepted, ovf stays 0, count stays 4. Assert reset mid-drain → o_tx_valid=0, STAT=0x0001, o_leds=0.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Target-side endpoint for the 16-bit CPU memory bus: on-chip RAM plus a small
// I/O page (LEDs, synchronized switches, cycle counter, byte TX FIFO with status).
module mem_bus_responder #(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [15:0] MMIO_BASE = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_mem_wrdata,
  output logic [15:0] o_mem_rddata,
  output logic [15:0] o_leds,
  input  logic [15:0] i_switches,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [16:0] RAM_BYTES = 17'(2 * RAM_WORDS);

  localparam logic [2:0] SEL_LED  = 3'd0;
  localparam logic [2:0] SEL_SW   = 3'd1;
  localparam logic [2:0] SEL_CYC  = 3'd2;
  localparam logic [2:0] SEL_TXD  = 3'd3;
  localparam logic [2:0] SEL_STAT = 3'd4;

  logic [15:0]   r_ram [RAM_WORDS];
  logic [7:0]    r_fifo [4];

  logic [15:0]   r_rddata;
  logic [15:0]   r_leds;
  logic [15:0]   r_sw_meta;
  logic [15:0]   r_sw_sync;
  logic [15:0]   r_cycle;
  logic [1:0]    r_head;
  logic [1:0]    r_tail;
  logic [2:0]    r_count;
  logic          r_ovf;

  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [2:0]    w_sel;
  logic [AW-1:0] w_ram_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_stat_clr;
  logic [15:0]   w_rd_data;

  assign w_ram_hit  = {1'b0, i_mem_addr} < RAM_BYTES;
  assign w_mmio_hit = i_mem_addr[15:4] == MMIO_BASE[15:4];
  assign w_sel      = i_mem_addr[3:1];
  assign w_ram_idx  = i_mem_addr[AW:1];

  assign w_empty    = r_count == 3'd0;
  assign w_full     = r_count == 3'd4;
  assign w_pop      = !w_empty && i_tx_ready;
  assign w_push_req = i_mem_wr && !w_ram_hit && w_mmio_hit && (w_sel == SEL_TXD);
  // A full FIFO can still take a byte when the head leaves on the same edge.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_stat_clr = i_mem_wr && !w_ram_hit && w_mmio_hit && (w_sel == SEL_STAT)
                      && i_mem_wrdata[2];

  assign o_mem_rddata = r_rddata;
  assign o_leds       = r_leds;
  assign o_tx_valid   = !w_empty;
  assign o_tx_data    = w_empty ? 8'h00 : r_fifo[r_head];

  always_comb begin
    w_rd_data = 16'h0000;
    if (w_ram_hit) begin
      w_rd_data = r_ram[w_ram_idx];
    end else if (w_mmio_hit) begin
      case (w_sel)
        SEL_LED:  w_rd_data = r_leds;
        SEL_SW:   w_rd_data = r_sw_sync;
        SEL_CYC:  w_rd_data = r_cycle;
        SEL_STAT: w_rd_data = {10'b0, r_count, r_ovf, w_full, w_empty};
        default:  w_rd_data = 16'h0000;
      endcase
    end
  end

  // Storage arrays carry no reset; the FIFO is emptied through its pointers.
  always_ff @(posedge clk) begin
    if (i_mem_wr && w_ram_hit) begin
      r_ram[w_ram_idx] <= i_mem_wrdata;
    end
    if (w_push_ok) begin
      r_fifo[r_tail] <= i_mem_wrdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rddata  <= 16'h0000;
      r_leds    <= 16'h0000;
      r_sw_meta <= 16'h0000;
      r_sw_sync <= 16'h0000;
      r_cycle   <= 16'h0000;
    end else begin
      r_sw_meta <= i_switches;
      r_sw_sync <= r_sw_meta;
      r_cycle   <= r_cycle + 16'd1;
      if (i_mem_rd) begin
        r_rddata <= w_rd_data;
      end
      if (i_mem_wr && !w_ram_hit && w_mmio_hit && (w_sel == SEL_LED)) begin
        r_leds <= i_mem_wrdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      r_count <= 3'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + 2'd1;
      end
      if (w_push_ok) begin
        r_tail <= r_tail + 2'd1;
      end
      r_count <= r_count + {2'b0, w_push_ok} - {2'b0, w_pop};
      if (w_push_req && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_stat_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a vector table for bus reads/writes,
// then hand-written sequences for the cycle counter, TX FIFO and mid-run reset.
module tb_mem_bus_responder;

  logic        clk;
  logic        reset;
  logic [15:0] i_mem_addr;
  logic        i_mem_rd;
  logic        i_mem_wr;
  logic [15:0] i_mem_wrdata;
  logic [15:0] o_mem_rddata;
  logic [15:0] o_leds;
  logic [15:0] i_switches;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] modelCyc;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chkRd;
    logic [15:0] expRd;
    logic [15:0] expLeds;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  mem_bus_responder dut (
    .clk          (clk),
    .reset        (reset),
    .i_mem_addr   (i_mem_addr),
    .i_mem_rd     (i_mem_rd),
    .i_mem_wr     (i_mem_wr),
    .i_mem_wrdata (i_mem_wrdata),
    .o_mem_rddata (o_mem_rddata),
    .o_leds       (o_leds),
    .i_switches   (i_switches),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference free-running counter: value the DUT counter holds between edges.
  always @(posedge clk or posedge reset) begin
    if (reset) modelCyc <= 16'h0000;
    else       modelCyc <= modelCyc + 16'd1;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] data);
    i_mem_rd     = rd;
    i_mem_wr     = wr;
    i_mem_addr   = addr;
    i_mem_wrdata = data;
    @(negedge clk);
    i_mem_rd = 1'b0;
    i_mem_wr = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    i_mem_rd = 1'b0;
    i_mem_wr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] expCyc;
    int guard;

    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 16'h0020, 16'h2222, 1'b1, 16'h1111, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h2222, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 16'hF000, 16'h00A5, 1'b1, 16'h2222, 16'h00A5};
    vecs[7]  = '{1'b1, 1'b0, 16'hF002, 16'h0000, 1'b1, 16'h1234, 16'h00A5};
    vecs[8]  = '{1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h0000, 16'h00A5};
    vecs[9]  = '{1'b0, 1'b1, 16'hF002, 16'hFFFF, 1'b0, 16'h0000, 16'h00A5};
    vecs[10] = '{1'b1, 1'b0, 16'hF002, 16'h0000, 1'b1, 16'h1234, 16'h00A5};
    vecs[11] = '{1'b1, 1'b0, 16'hF006, 16'h0000, 1'b1, 16'h0000, 16'h00A5};
    vecs[12] = '{1'b1, 1'b0, 16'hF00A, 16'h0000, 1'b1, 16'h0000, 16'h00A5};
    vecs[13] = '{1'b1, 1'b1, 16'hF000, 16'h5A5A, 1'b1, 16'h00A5, 16'h5A5A};
    vecs[14] = '{1'b1, 1'b0, 16'hF000, 16'h0000, 1'b1, 16'h5A5A, 16'h5A5A};
    vecs[15] = '{1'b0, 1'b1, 16'h0000, 16'h1357, 1'b0, 16'h0000, 16'h5A5A};
    vecs[16] = '{1'b0, 1'b1, 16'h1FFE, 16'hCAFE, 1'b0, 16'h0000, 16'h5A5A};
    vecs[17] = '{1'b0, 1'b1, 16'h2000, 16'hFFFF, 1'b0, 16'h0000, 16'h5A5A};
    vecs[18] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0000, 16'h5A5A};
    vecs[19] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1357, 16'h5A5A};
    vecs[20] = '{1'b1, 1'b0, 16'h1FFE, 16'h0000, 1'b1, 16'hCAFE, 16'h5A5A};
    vecs[21] = '{1'b1, 1'b0, 16'hEFFE, 16'h0000, 1'b1, 16'h0000, 16'h5A5A};
    vecs[22] = '{1'b1, 1'b0, 16'hF010, 16'h0000, 1'b1, 16'h0000, 16'h5A5A};

    reset        = 1'b1;
    i_mem_addr   = 16'h0000;
    i_mem_rd     = 1'b0;
    i_mem_wr     = 1'b0;
    i_mem_wrdata = 16'h0000;
    i_switches   = 16'h1234;
    i_tx_ready   = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_rddata", o_mem_rddata, 16'h0000);
    checkOutput("reset_leds", o_leds, 16'h0000);
    checkOutput("reset_tx_valid", {15'b0, o_tx_valid}, 16'h0000);
    checkOutput("reset_tx_data", {8'b0, o_tx_data}, 16'h0000);
    reset = 1'b0;

    // First edge after reset reads the counter's reset value.
    applyStimulus(1'b1, 1'b0, 16'hF004, 16'h0000);
    checkOutput("cyc_first", o_mem_rddata, 16'h0000);
    expCyc = modelCyc;
    applyStimulus(1'b1, 1'b0, 16'hF004, 16'h0000);
    checkOutput("cyc_model", o_mem_rddata, expCyc);
    idleCycles(9);
    applyStimulus(1'b1, 1'b0, 16'hF004, 16'h0000);
    checkOutput("cyc_delta10", o_mem_rddata, expCyc + 16'd10);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chkRd) checkOutput($sformatf("vec%0d_rddata", i), o_mem_rddata, vecs[i].expRd);
      checkOutput($sformatf("vec%0d_leds", i), o_leds, vecs[i].expLeds);
    end

    applyStimulus(1'b1, 1'b0, 16'hF008, 16'h0000);
    checkOutput("stat_empty", o_mem_rddata, 16'h0001);
    applyStimulus(1'b0, 1'b1, 16'hF006, 16'h0041);
    checkOutput("push_empty_valid", {15'b0, o_tx_valid}, 16'h0001);
    checkOutput("push_empty_data", {8'b0, o_tx_data}, 16'h0041);
    for (int b = 16'h42; b <= 16'h44; b++) applyStimulus(1'b0, 1'b1, 16'hF006, 16'(b));
    applyStimulus(1'b1, 1'b0, 16'hF008, 16'h0000);
    checkOutput("stat_full", o_mem_rddata, 16'h0022);
    applyStimulus(1'b0, 1'b1, 16'hF006, 16'h0045);
    applyStimulus(1'b1, 1'b0, 16'hF008, 16'h0000);
    checkOutput("stat_full_ovf", o_mem_rddata, 16'h0026);
    checkOutput("head_after_ovf", {8'b0, o_tx_data}, 16'h0041);

    i_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d_valid", i), {15'b0, o_tx_valid}, 16'h0001);
      checkOutput($sformatf("drain%0d_data", i), {8'b0, o_tx_data}, 16'(16'h41 + i));
      @(negedge clk);
    end
    i_tx_ready = 1'b0;
    checkOutput("drained_valid", {15'b0, o_tx_valid}, 16'h0000);
    checkOutput("drained_data", {8'b0, o_tx_data}, 16'h0000);

    applyStimulus(1'b1, 1'b0, 16'hF008, 16'h0000);
    checkOutput("stat_empty_ovf", o_mem_rddata, 16'h0005);
    applyStimulus(1'b0, 1'b1, 16'hF008, 16'h00FB);
    applyStimulus(1'b1, 1'b0, 16'hF008, 16'h0000);
    checkOutput("stat_noclear", o_mem_rddata, 16'h0005);
    applyStimulus(1'b0, 1'b1, 16'hF008, 16'h0004);
    applyStimulus(1'b1, 1'b0, 16'hF008, 16'h0000);
    checkOutput("stat_cleared", o_mem_rddata, 16'h0001);

    // Push and pop on the same edge with two entries queued.
    applyStimulus(1'b0, 1'b1, 16'hF006, 16'h0010);
    applyStimulus(1'b0, 1'b1, 16'hF006, 16'h0011);
    i_tx_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'hF006, 16'h0012);
    i_tx_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'hF008, 16'h0000);
    checkOutput("stat_pushpop", o_mem_rddata, 16'h0010);
    checkOutput("head_pushpop", {8'b0, o_tx_data}, 16'h0011);
    i_tx_ready = 1'b1;
    @(negedge clk);
    checkOutput("head_wrap", {8'b0, o_tx_data}, 16'h0012);
    @(negedge clk);
    i_tx_ready = 1'b0;
    checkOutput("pushpop_empty", {15'b0, o_tx_valid}, 16'h0000);

    guard = 0;
    while (modelCyc != 16'hFFFF && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("cyc_wait_bound", 16'(guard < 70000), 16'h0001);
    applyStimulus(1'b1, 1'b0, 16'hF004, 16'h0000);
    checkOutput("cyc_ffff", o_mem_rddata, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 16'hF004, 16'h0000);
    checkOutput("cyc_wrap", o_mem_rddata, 16'h0000);

    for (int b = 16'h60; b <= 16'h63; b++) applyStimulus(1'b0, 1'b1, 16'hF006, 16'(b));
    i_tx_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'hF006, 16'h0055);
    i_tx_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'hF008, 16'h0000);
    checkOutput("stat_full_pushpop", o_mem_rddata, 16'h0022);
    checkOutput("head_full_pushpop", {8'b0, o_tx_data}, 16'h0061);

    i_tx_ready = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_valid", {15'b0, o_tx_valid}, 16'h0000);
    checkOutput("midreset_data", {8'b0, o_tx_data}, 16'h0000);
    checkOutput("midreset_leds", o_leds, 16'h0000);
    checkOutput("midreset_rddata", o_mem_rddata, 16'h0000);
    i_tx_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'hF008, 16'h0000);
    checkOutput("stat_after_reset", o_mem_rddata, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
